// File: rtl/ap_ddr_pkg.sv
// Shared encodings for the DDR read-port arbiter: FSM states, owner codes and the default burst clamp.
package ap_ddr_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_ISA  = 2'd1,
        OWN_DAT  = 2'd2
    } owner_t;

    localparam int MAX_BURST_LEN_DEF = 128;

endpackage

// File: rtl/ddr_arb_pick.sv
// Combinational two-way picker between ISA refill and data loader.
// DDR_ARB_RR_EN selects round-robin on ties; otherwise ISA always wins.
module ddr_arb_pick
    import ap_ddr_pkg::*;
(
    input  logic   isa_req,
    input  logic   dat_req,
`ifdef DDR_ARB_RR_EN
    input  owner_t last,
`endif
    output owner_t win
);

    always_comb begin
        win = OWN_NONE;
`ifdef DDR_ARB_RR_EN
        if (isa_req && dat_req) win = (last == OWN_ISA) ? OWN_DAT : OWN_ISA;
        else if (isa_req)       win = OWN_ISA;
        else if (dat_req)       win = OWN_DAT;
`else
        if (isa_req)            win = OWN_ISA;
        else if (dat_req)       win = OWN_DAT;
`endif
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Grants the single DDR read-burst port to ISA refill or data loader and steers beats to the owner.
// Build option DDR_ARB_RR_EN: round-robin tie-break instead of fixed ISA priority.
module ddr_rd_arbiter
    import ap_ddr_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 10,
    parameter int MAX_BURST_LEN  = MAX_BURST_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      isa_req,
    input  logic [DDR_ADDR_WIDTH-1:0] isa_addr,
    input  logic [LEN_WIDTH-1:0]      isa_len,
    output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
    output logic                      isa_data_valid,
    input  logic                      dat_req,
    input  logic [DDR_ADDR_WIDTH-1:0] dat_addr,
    input  logic [LEN_WIDTH-1:0]      dat_len,
    output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
    output logic                      dat_data_valid,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [LEN_WIDTH-1:0]      rd_burst_len,
    input  logic                      rd_burst_data_valid,
    input  logic [DATA_WIDTH-1:0]     rd_burst_data,
    input  logic                      rd_burst_finish,
    output logic [1:0]                owner,
    output logic [1:0]                st_cur_arb
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST_LEN);

    arb_state_t           state, state_nxt;
    owner_t               own, win;
    logic [LEN_WIDTH-1:0] win_len, own_cnt;
    logic                 own_req, beat, last_beat;

`ifdef DDR_ARB_RR_EN
    owner_t last_owner;

    ddr_arb_pick u_pick (
        .isa_req (isa_req),
        .dat_req (dat_req),
        .last    (last_owner),
        .win     (win)
    );
`else
    ddr_arb_pick u_pick (
        .isa_req (isa_req),
        .dat_req (dat_req),
        .win     (win)
    );
`endif

    always_comb begin
        win_len = (win == OWN_ISA) ? isa_len : dat_len;
        if (win_len > MAX_LEN) win_len = MAX_LEN;
    end

    assign own_cnt = (own == OWN_ISA) ? isa_rd_cnt : dat_rd_cnt;
    assign own_req = (own == OWN_ISA) ? isa_req : ((own == OWN_DAT) && dat_req);
    // Beats beyond the latched length are dropped, so the counter saturates.
    assign beat      = (state == ARB_BURST) && rd_burst_data_valid && (own_cnt < rd_burst_len);
    assign last_beat = beat && (own_cnt == rd_burst_len - LEN_WIDTH'(1));

    assign rd_burst_req = (state == ARB_BURST);
    assign owner        = own;
    assign st_cur_arb   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (win != OWN_NONE) state_nxt = (win_len == '0) ? ARB_DONE : ARB_BURST;
            ARB_BURST: if (rd_burst_finish || last_beat) state_nxt = ARB_DONE;
            // Waiting for the owner to drop req keeps a held request from being re-granted.
            ARB_DONE:  if (!own_req) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ARB_IDLE;
            own            <= OWN_NONE;
            rd_burst_addr  <= '0;
            rd_burst_len   <= '0;
            rd_data        <= '0;
            isa_rd_cnt     <= '0;
            dat_rd_cnt     <= '0;
            isa_data_valid <= 1'b0;
            dat_data_valid <= 1'b0;
`ifdef DDR_ARB_RR_EN
            last_owner     <= OWN_DAT;
`endif
        end else begin
            state          <= state_nxt;
            isa_data_valid <= 1'b0;
            dat_data_valid <= 1'b0;
            if (state == ARB_IDLE && win != OWN_NONE) begin
                own           <= win;
                rd_burst_addr <= (win == OWN_ISA) ? isa_addr : dat_addr;
                rd_burst_len  <= win_len;
                if (win == OWN_ISA) isa_rd_cnt <= '0;
                else                dat_rd_cnt <= '0;
`ifdef DDR_ARB_RR_EN
                last_owner    <= win;
`endif
            end
            if (state == ARB_DONE && !own_req) own <= OWN_NONE;
            if (beat) begin
                rd_data <= rd_burst_data;
                if (own == OWN_ISA) begin
                    isa_data_valid <= 1'b1;
                    isa_rd_cnt     <= isa_rd_cnt + LEN_WIDTH'(1);
                end else begin
                    dat_data_valid <= 1'b1;
                    dat_rd_cnt     <= dat_rd_cnt + LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Randomized scoreboard bench for ddr_rd_arbiter; expectations come from a transaction-level model.
// Works in both builds (DDR_ARB_RR_EN defined or not).
module tb_ddr_rd_arbiter;

    localparam int AW   = 28;
    localparam int DW   = 32;
    localparam int LW   = 10;
    localparam int MAXL = 128;

    typedef struct { int own; logic [DW-1:0] data; int cnt; } beat_t;
    typedef struct { int own; logic [AW-1:0] addr; int len; } grant_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          isa_req = 1'b0, dat_req = 1'b0;
    logic [AW-1:0] isa_addr = '0, dat_addr = '0;
    logic [LW-1:0] isa_len = '0, dat_len = '0;
    logic [LW-1:0] isa_rd_cnt, dat_rd_cnt;
    logic          isa_data_valid, dat_data_valid;
    logic [DW-1:0] rd_data;
    logic          rd_burst_req;
    logic [AW-1:0] rd_burst_addr;
    logic [LW-1:0] rd_burst_len;
    logic          rd_burst_data_valid = 1'b0;
    logic [DW-1:0] rd_burst_data = '0;
    logic          rd_burst_finish = 1'b0;
    logic [1:0]    owner, st_cur_arb;

    always #5 clk = ~clk;

    ddr_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .isa_req(isa_req), .isa_addr(isa_addr), .isa_len(isa_len),
        .isa_rd_cnt(isa_rd_cnt), .isa_data_valid(isa_data_valid),
        .dat_req(dat_req), .dat_addr(dat_addr), .dat_len(dat_len),
        .dat_rd_cnt(dat_rd_cnt), .dat_data_valid(dat_data_valid),
        .rd_data(rd_data), .rd_burst_req(rd_burst_req),
        .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .rd_burst_finish(rd_burst_finish), .owner(owner), .st_cur_arb(st_cur_arb)
    );

    int     n_chk = 0, n_pass = 0;
    grant_t exp_g[$];
    beat_t  exp_b[$];
    int     last_own = 1;     // 0 = ISA, 1 = DAT; reset value is DAT
    int     cnt_m[2] = '{0, 0};
    logic   prev_req = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic int model_pick(input bit a, input bit b);
        if (a && b) begin
`ifdef DDR_ARB_RR_EN
            return (last_own == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return a ? 0 : 1;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a beat or starts a burst.
    always @(negedge clk) begin
        beat_t  b;
        grant_t g;
        if (rst) begin
            if (isa_data_valid && dat_data_valid) chk("both_valid", dat_data_valid, 0);
            else if (isa_data_valid || dat_data_valid) begin
                if (exp_b.size() == 0) chk("unexpected_beat", exp_b.size(), 1);
                else begin
                    b = exp_b.pop_front();
                    chk("beat_owner", isa_data_valid ? 1 : 2, b.own);
                    chk("beat_data", rd_data, b.data);
                    chk("beat_cnt", isa_data_valid ? isa_rd_cnt : dat_rd_cnt, b.cnt);
                end
            end
            if (rd_burst_req && !prev_req) begin
                if (exp_g.size() == 0) chk("unexpected_grant", exp_g.size(), 1);
                else begin
                    g = exp_g.pop_front();
                    chk("grant_owner", owner, g.own);
                    chk("grant_addr", rd_burst_addr, g.addr);
                    chk("grant_len", rd_burst_len, g.len);
                end
            end
        end
        prev_req = rd_burst_req;
    end

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, st_cur_arb, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_req"}, rd_burst_req, 0);
        chk({tag, "_addr"}, rd_burst_addr, 0);
        chk({tag, "_len"}, rd_burst_len, 0);
        chk({tag, "_data"}, rd_data, 0);
        chk({tag, "_isa_cnt"}, isa_rd_cnt, 0);
        chk({tag, "_dat_cnt"}, dat_rd_cnt, 0);
        chk({tag, "_isa_v"}, isa_data_valid, 0);
        chk({tag, "_dat_v"}, dat_data_valid, 0);
    endtask

    // DDR side: nb beats with random gaps, finish pulse after beat fin; model counts accepted beats.
    task automatic serve(input int w, input int len, input int nb, input int fin, output int acc);
        bit stop;
        stop = 0;
        acc  = 0;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            rd_burst_data       = $urandom;
            rd_burst_data_valid = 1'b1;
            if (!stop && acc < len) begin
                acc++;
                exp_b.push_back(beat_t'{w + 1, rd_burst_data, acc});
            end
            tick();
            rd_burst_data_valid = 1'b0;
            if (i + 1 == fin) begin
                rd_burst_finish = 1'b1;
                tick();
                rd_burst_finish = 1'b0;
                stop = 1;
            end
        end
    endtask

    task automatic do_txn(input bit e0, input bit e1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input int l0, input int l1, input int nb0, input int nb1,
                          input int fin0, input int fin1, input int hold);
        bit            pend[2];
        logic [AW-1:0] ad[2];
        int            ln[2], nb[2], fn[2];
        int            w, len, acc;
        bit            first;
        pend = '{e0, e1};
        ad   = '{a0, a1};
        ln   = '{l0, l1};
        nb   = '{nb0, nb1};
        fn   = '{fin0, fin1};
        isa_addr = a0; isa_len = LW'(l0);
        dat_addr = a1; dat_len = LW'(l1);
        first = 1;
        while (pend[0] || pend[1]) begin
            w        = model_pick(pend[0], pend[1]);
            pend[w]  = 0;
            last_own = w;
            len      = (ln[w] > MAXL) ? MAXL : ln[w];
            cnt_m[w] = 0;
            if (len > 0) exp_g.push_back(grant_t'{w + 1, ad[w], len});
            if (first) begin
                isa_req = e0;
                dat_req = e1;
                first   = 0;
            end
            if (len > 0) begin
                for (int k = 0; k < 20 && !rd_burst_req; k++) tick();
                chk("grant_seen", rd_burst_req, 1);
                serve(w, len, nb[w], fn[w], acc);
                cnt_m[w] = acc;
            end
            for (int k = 0; k < 20 && st_cur_arb != 2'd2; k++) tick();
            @(negedge clk);
            chk("done_state", st_cur_arb, 2);
            chk("done_req", rd_burst_req, 0);
            chk("done_owner", owner, w + 1);
            chk("isa_cnt", isa_rd_cnt, cnt_m[0]);
            chk("dat_cnt", dat_rd_cnt, cnt_m[1]);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("hold_state", st_cur_arb, 2);
                chk("hold_req", rd_burst_req, 0);
            end
            tick();
            if (w == 0) isa_req = 1'b0;
            else        dat_req = 1'b0;
        end
        tick();
        tick();
        @(negedge clk);
        chk("idle_owner", owner, 0);
        chk("idle_state", st_cur_arb, 0);
    endtask

    initial begin
        bit e0, e1;
        int l0, l1, n0, n1, f0, f1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        tick();
        rst = 1'b1;
        tick();

        do_txn(1, 0, 28'h400, 28'h0, 16, 0, 16, 0, 16, 0, 1);            // ISA alone
        do_txn(1, 1, 28'h1000, 28'h2000, 4, 6, 4, 6, 4, 6, 1);          // first tie
        do_txn(1, 1, 28'h3000, 28'h4000, 5, 3, 5, 3, 5, 3, 1);          // second tie
        do_txn(0, 1, 28'h0, 28'h8000, 0, 300, 0, 130, 0, 130, 1);       // clamp to 128
        do_txn(1, 0, 28'h500, 28'h0, 8, 0, 5, 0, 5, 0, 1);              // early finish
        do_txn(1, 0, 28'h600, 28'h0, 3, 0, 3, 0, 3, 0, 10);             // held request
        do_txn(0, 1, 28'h0, 28'h700, 0, 0, 0, 0, 0, 0, 1);              // zero length

        for (int t = 0; t < 8; t++) begin
            e0 = 1'($urandom_range(0, 1));
            e1 = 1'($urandom_range(0, 1));
            if (!e0 && !e1) e1 = 1'b1;
            l0 = $urandom_range(1, 24);
            l1 = $urandom_range(1, 24);
            n0 = l0 + $urandom_range(0, 2);
            n1 = l1 + $urandom_range(0, 2);
            f0 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n0) : n0;
            f1 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n1) : n1;
            do_txn(e0, e1, AW'($urandom), AW'($urandom), l0, l1, n0, n1, f0, f1, 1);
        end

        // Reset asserted on the third beat of an ISA burst.
        isa_addr = 28'h900;
        isa_len  = 10'd8;
        isa_req  = 1'b1;
        last_own = model_pick(1, 0);
        cnt_m[0] = 0;
        exp_g.push_back(grant_t'{1, 28'h900, 8});
        for (int k = 0; k < 20 && !rd_burst_req; k++) tick();
        chk("rst_grant_seen", rd_burst_req, 1);
        for (int i = 1; i <= 2; i++) begin
            rd_burst_data       = $urandom;
            rd_burst_data_valid = 1'b1;
            exp_b.push_back(beat_t'{1, rd_burst_data, i});
            tick();
            rd_burst_data_valid = 1'b0;
            tick();
        end
        rd_burst_data       = $urandom;
        rd_burst_data_valid = 1'b1;
        rst                 = 1'b0;
        isa_req             = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        rd_burst_data_valid = 1'b0;
        tick();
        rst      = 1'b1;
        last_own = 1;
        cnt_m    = '{0, 0};
        tick();
        do_txn(0, 1, 28'h0, 28'hA00, 0, 7, 0, 7, 0, 7, 1);

        chk("beats_left", exp_b.size(), 0);
        chk("grants_left", exp_g.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Arbitrates the single DDR read-burst port between two requesters: the instruction cache (ISA refill) and the data loader (LOADRBR/LOADCBC operand fetch). It grants one requester at a time and forwards that requester's address and length to the DDR interface. Return data, a valid strobe and a per-requester beat count are steered back to the owner only. It sits between `ins_cache`/data-load logic and the DDR interface module.

## Interface
- `DDR_ADDR_WIDTH`, 28, DDR byte-address width
- `DATA_WIDTH`, 32, DDR read data width; broadcast to both requesters
- `LEN_WIDTH`, 10, burst length / beat count width
- `MAX_BURST_LEN`, 128, largest burst issued; longer requests are clamped
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `isa_req`  in  1  ISA refill request; held until `isa_rd_cnt >= isa_len`
- `isa_addr`  in  DDR_ADDR_WIDTH  ISA burst start address
- `isa_len`  in  LEN_WIDTH  ISA beats requested
- `isa_rd_cnt`  out  LEN_WIDTH  beats delivered to ISA in current grant
- `isa_data_valid`  out  1  beat valid for ISA
- `dat_req`, `dat_addr`, `dat_len`, `dat_rd_cnt`, `dat_data_valid`: same as the ISA signals, for the data loader
- `rd_data`  out  DATA_WIDTH  registered copy of `rd_burst_data`
- `rd_burst_req`  out  1  burst request to DDR interface
- `rd_burst_addr`  out  DDR_ADDR_WIDTH  latched owner address
- `rd_burst_len`  out  LEN_WIDTH  latched, clamped owner length
- `rd_burst_data_valid`  in  1  DDR beat valid
- `rd_burst_data`  in  DATA_WIDTH  DDR beat data
- `rd_burst_finish`  in  1  DDR burst complete pulse
- `owner`  out  2  0 none, 1 ISA, 2 DAT
- `st_cur_arb`  out  2  current state, for debug

## Operation
- States: IDLE(0), BURST(1), DONE(2).
- IDLE:
  - Sample `isa_req`/`dat_req`. If any request is asserted, pick a winner and latch its addr and `min(len, MAX_BURST_LEN)`.
  - Clear the winner's `*_rd_cnt` to 0, set `owner`, and go to BURST.
  - If the latched length is 0, go to DONE instead; no DDR request is issued.
- BURST:
  - `rd_burst_req` is held at 1.
  - Each `rd_burst_data_valid` beat is registered: `rd_data` <= data, and the owner's `*_data_valid` pulses one cycle later. The owner's `*_rd_cnt` increments in that same delayed cycle.
  - Go to DONE when the owner's count reaches the latched length, or on `rd_burst_finish`, whichever comes first.
  - Beats arriving after the count reaches the length are dropped.
- DONE:
  - `rd_burst_req` = 0. The owner's `*_rd_cnt` holds its final value.
  - Stay in DONE until the owner's `req` is 0, then go to IDLE with `owner` = 0.
  - This prevents a still-high request from being re-granted.
- A requester dropping `req` mid-BURST does not abort the burst. The arbiter completes the burst and its data remains gated to that owner.
- The non-owner's `*_data_valid` is always 0. Its `*_rd_cnt` holds its last value.
- Counters are LEN_WIDTH wide and saturate at the latched length; they never wrap.
- Fixed priority: ISA beats DAT on a simultaneous request, because an instruction fetch stalls the pipeline.

## Timing
- Reset values:
  - `st_cur_arb` = IDLE, `owner` = 0, `rd_burst_req` = 0.
  - addr, len, `rd_data` and both rd_cnt outputs = 0.
  - Both `*_data_valid` = 0.
  - RR pointer = DAT (last owner).
- Grant latency: a request seen in IDLE at cycle N gives `rd_burst_req` = 1 at cycle N+1.
- Data latency: `rd_burst_data_valid` at cycle M gives owner valid, `rd_data` and the incremented count at cycle M+1.
- DONE lasts at least one cycle. Back-to-back grants are therefore separated by at least 2 idle cycles on `rd_burst_req`.
- Reset mid-burst: state returns to IDLE immediately and all outputs go to their reset values. The DDR interface shares `rst`.

## Configuration
- `DDR_ARB_RR_EN` defined: round-robin arbitration.
  - On a simultaneous request, the requester that was not the last owner wins.
  - The last-owner pointer updates on each IDLE→BURST/DONE grant.
- Not defined: fixed ISA-over-DAT priority, no pointer register.

## Structure
- Package `ap_ddr_pkg` holds:
  - State encodings ARB_IDLE/ARB_BURST/ARB_DONE.
  - Owner encodings OWN_NONE/OWN_ISA/OWN_DAT.
  - The MAX_BURST_LEN default.
- One sub-module, `ddr_arb_pick`: a combinational two-way picker. Inputs are the two requests and the last-owner pointer; output is the winner. It contains the fixed vs RR logic under `DDR_ARB_RR_EN`.

## Test plan
- ISA alone, `isa_len` = 16, addr 0x400:
  - `rd_burst_addr` = 0x400, `rd_burst_len` = 16.
  - 16 `isa_data_valid` pulses, `isa_rd_cnt` ends at 16, `dat_data_valid` never set.
- `isa_req` and `dat_req` rise in the same cycle:
  - Fixed build: ISA is granted first, DAT after ISA drops its request.
  - RR build, second tie: DAT wins.
- `dat_len` = 300: `rd_burst_len` = 128, `dat_rd_cnt` stops at 128.
- `rd_burst_finish` after 5 of 8 beats: DONE is entered and `isa_rd_cnt` = 5.
- ISA holds `isa_req` high 10 cycles after completion: the arbiter stays in DONE, with no re-grant and no `rd_burst_req`.
- `rst` low mid-burst at beat 3: all outputs reset within the same cycle. After release, a new DAT request is granted normally.
